// File: rtl/delta_sigma_modulator.sv
// Delta-sigma modulator: signed PCM in, one pulse-density bit out per clock.
// First- or second-order loop; integrators saturate so an overloaded loop recovers instead of wrapping.
module delta_sigma_modulator #(
  parameter int DATA_W = 16,
  parameter int INT_W  = 20,
  parameter int ORDER  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     quant_out
);

  // Two guard bits above INT_W hold the exact three-term sum before clamping.
  localparam int SW = INT_W + 2;
  localparam logic signed [SW-1:0] FS_EXT  = {{(SW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(INT_W-1){1'b0}}};

  if (ORDER != 1 && ORDER != 2) begin : g_badOrder
    $error("delta_sigma_modulator: ORDER must be 1 or 2");
  end

  if (INT_W < DATA_W + 3) begin : g_badWidth
    $error("delta_sigma_modulator: INT_W must be at least DATA_W+3");
  end

  logic signed [INT_W-1:0] r_i1;
  logic signed [INT_W-1:0] r_i2;
  logic                    r_quant;

  logic signed [SW-1:0]    w_fb;
  logic signed [SW-1:0]    w_dataExt;
  logic signed [SW-1:0]    w_i1Ext;
  logic signed [SW-1:0]    w_i2Ext;
  logic signed [SW-1:0]    w_i1NextExt;
  logic signed [SW-1:0]    w_i1Sum;
  logic signed [SW-1:0]    w_i2Sum;
  logic signed [INT_W-1:0] w_i1Next;
  logic signed [INT_W-1:0] w_i2Next;
  logic                    w_quantNext;

  function automatic logic signed [INT_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] clamped;
    if (v > SAT_MAX)      clamped = SAT_MAX;
    else if (v < SAT_MIN) clamped = SAT_MIN;
    else                  clamped = v;
    return clamped[INT_W-1:0];
  endfunction

  // Feedback comes from the registered bit, so the first edge after reset sees -FS.
  always_comb begin
    w_fb        = r_quant ? FS_EXT : -FS_EXT;
    w_dataExt   = {{(SW-DATA_W){data_in[DATA_W-1]}}, data_in};
    w_i1Ext     = {{2{r_i1[INT_W-1]}}, r_i1};
    w_i2Ext     = {{2{r_i2[INT_W-1]}}, r_i2};
    w_i1Sum     = w_i1Ext + w_dataExt - w_fb;
    w_i1Next    = sat(w_i1Sum);
    w_i1NextExt = {{2{w_i1Next[INT_W-1]}}, w_i1Next};
    w_i2Sum     = w_i2Ext + w_i1NextExt - w_fb;
    w_i2Next    = sat(w_i2Sum);
    w_quantNext = (ORDER == 2) ? ~w_i2Next[INT_W-1] : ~w_i1Next[INT_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i1    <= '0;
      r_i2    <= '0;
      r_quant <= 1'b0;
    end else begin
      r_i1    <= w_i1Next;
      r_i2    <= (ORDER == 2) ? w_i2Next : '0;
      r_quant <= w_quantNext;
    end
  end

  assign quant_out = r_quant;

endmodule

// File: tb/tb_delta_sigma_modulator.sv
// Directed bench for delta_sigma_modulator: a second-order and a first-order instance share
// clock, reset and input; expected sequences and counts are worked out by hand from the loop equations.
module tb_delta_sigma_modulator;

  logic               clk;
  logic               reset;
  logic signed [15:0] data_in;
  logic               q2;
  logic               q1;

  int checks   = 0;
  int failures = 0;

  // Hand-derived zero-input trajectory of the second-order loop from reset (edges 1..12).
  int expQ2[12]  = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  int expI1[12]  = '{32768, 0, -32768, 0, -32768, 0, 32768, 0, -32768, 0, 32768, 0};
  int expI2[12]  = '{65536, 32768, -32768, 0, -65536, -32768, 32768, 0, -65536, -32768, 32768, 0};
  // First-order loop with zero input: 1,1 then strict alternation.
  int expQ1[12]  = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int expI1o1[12] = '{32768, 0, -32768, 0, -32768, 0, -32768, 0, -32768, 0, -32768, 0};

  delta_sigma_modulator #(.DATA_W(16), .INT_W(20), .ORDER(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .quant_out(q2)
  );

  delta_sigma_modulator #(.DATA_W(16), .INT_W(20), .ORDER(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .quant_out(q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input logic signed [31:0] observed,
                            input int lo, input int hi);
    checks++;
    assert (observed >= lo && observed <= hi) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=[%0d..%0d]", tag, observed, lo, hi);
    end
  endtask

  // Drive one sample, let the DUT take it on the next rising edge, then settle 1 time unit.
  task automatic applyStimulus(input logic signed [15:0] d);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset   = 1'b1;
    data_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int ones2;
    int ones1;
    int bufX[32];
    int bufY[32];
    int sumX;
    int sumY;
    int xv;
    real ph;

    reset   = 1'b1;
    data_in = '0;
    #22;
    $display("[TB] reset state");
    checkOutput("rst_q2", 32'(q2), 0);
    checkOutput("rst_q1", 32'(q1), 0);
    checkOutput("rst_i1", 32'(dut2.r_i1), 0);
    checkOutput("rst_i2", 32'(dut2.r_i2), 0);
    reset = 1'b0;

    $display("[TB] zero input trajectories");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(16'sd0);
      checkOutput("zero_q2", 32'(q2), expQ2[n]);
      checkOutput("zero_i1", 32'(dut2.r_i1), expI1[n]);
      checkOutput("zero_i2", 32'(dut2.r_i2), expI2[n]);
      checkOutput("zero_q1", 32'(q1), expQ1[n]);
      checkOutput("zero_o1_i1", 32'(dut1.r_i1), expI1o1[n]);
      checkOutput("zero_o1_i2", 32'(dut1.r_i2), 0);
    end
    ones2 = 0;
    ones1 = 0;
    for (int n = 0; n < 1024; n++) begin
      applyStimulus(16'sd0);
      if (q2) ones2++;
      if (q1) ones1++;
    end
    checkOutput("zero_density_o2", ones2, 512);
    checkRange("zero_density_o1", ones1, 511, 513);

    $display("[TB] DC +16384");
    resetDut();
    ones2 = 0;
    ones1 = 0;
    for (int n = 0; n < 1024; n++) begin
      applyStimulus(16'sd16384);
      if (q2) ones2++;
      if (q1) ones1++;
    end
    checkRange("dc_pos_o2", ones2, 758, 778);
    checkRange("dc_pos_o1", ones1, 758, 778);

    $display("[TB] DC -16384");
    resetDut();
    ones2 = 0;
    ones1 = 0;
    for (int n = 0; n < 1024; n++) begin
      applyStimulus(-16'sd16384);
      if (q2) ones2++;
      if (q1) ones1++;
    end
    checkRange("dc_neg_o2", ones2, 246, 266);
    checkRange("dc_neg_o1", ones1, 246, 266);

    $display("[TB] positive overload and recovery");
    resetDut();
    for (int n = 0; n < 200; n++) applyStimulus(16'sd32767);
    checkOutput("ovl_pos_i2", 32'(dut2.r_i2), 524287);
    checkOutput("ovl_pos_i1", 32'(dut2.r_i1), 65336);
    checkOutput("ovl_pos_q2", 32'(q2), 1);
    checkOutput("ovl_pos_o1_i1", 32'(dut1.r_i1), 65336);
    for (int n = 0; n < 64; n++) applyStimulus(16'sd0);
    ones2 = 0;
    for (int n = 0; n < 512; n++) begin
      applyStimulus(16'sd0);
      if (q2) ones2++;
    end
    checkRange("ovl_recover_o2", ones2, 231, 281);

    $display("[TB] negative overload");
    resetDut();
    for (int n = 0; n < 200; n++) applyStimulus(-16'sd32768);
    checkOutput("ovl_neg_i2", 32'(dut2.r_i2), -524288);
    checkOutput("ovl_neg_i1", 32'(dut2.r_i1), -65536);
    checkOutput("ovl_neg_q2", 32'(q2), 0);

    $display("[TB] sine tracking");
    resetDut();
    sumX = 0;
    sumY = 0;
    for (int n = 0; n < 32; n++) begin
      bufX[n] = 0;
      bufY[n] = 0;
    end
    for (int k = 0; k < 3600; k++) begin
      ph = 1000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 360.0);
      xv = (ph >= 0.0) ? $rtoi(ph + 0.5) : -$rtoi(-ph + 0.5);
      applyStimulus(16'(xv));
      sumX = sumX - bufX[k % 32] + xv;
      bufX[k % 32] = xv;
      sumY = sumY - bufY[k % 32] + (q2 ? 32768 : -32768);
      bufY[k % 32] = q2 ? 32768 : -32768;
      if (k >= 64 && (k % 8) == 0)
        checkRange("sine_avg32", sumY - sumX, -131072, 131072);
    end

    $display("[TB] asynchronous reset mid-cycle");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_q2", 32'(q2), 0);
    checkOutput("arst_i1", 32'(dut2.r_i1), 0);
    checkOutput("arst_i2", 32'(dut2.r_i2), 0);
    checkOutput("arst_q1", 32'(q1), 0);
    @(posedge clk);
    #1;
    checkOutput("arst_hold_q2", 32'(q2), 0);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(16'sd0);
      checkOutput("arst_zero_q2", 32'(q2), expQ2[n]);
      checkOutput("arst_zero_i1", 32'(dut2.r_i1), expI1[n]);
      checkOutput("arst_zero_i2", 32'(dut2.r_i2), expI2[n]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
